// File: rtl/ram_cmd_arbiter_if.sv
// -----------------------------------------------------------------------------
// ram_cmd_arbiter_if
//
// Purpose : Bundles the two requester channels, the shared response bus and the
//           RAM command/readback signals that the arbiter sits between.
//
// Signal summary
//   reqN_valid   requester N has a complete transaction pending
//   reqN_ready   arbiter accepts requester N this cycle (transfer on valid&ready)
//   reqN_wr      1 = write, 0 = read
//   reqN_addr    RAM address (ADDR_SIZE bits, zero-extended into the payload)
//   reqN_wdata   write data, ignored for reads
//   respN_valid  one-cycle completion pulse for requester N
//   resp_rdata   read data shared by both requesters, qualified by respN_valid
//   resp_err     read timeout flag, qualified by respN_valid
//   ram_din      command word {op[1:0], payload[7:0]} to the RAM
//   ram_rx_valid command strobe to the RAM
//   ram_dout     RAM read data
//   ram_tx_valid RAM read-data valid
//
// Modports
//   slave  : the arbiter's view
//   master : the environment's view (requesters plus RAM)
// -----------------------------------------------------------------------------
interface ram_cmd_arbiter_if #(
   parameter int ADDR_SIZE = 8
);
   logic                 req0_valid;
   logic                 req0_ready;
   logic                 req0_wr;
   logic [ADDR_SIZE-1:0] req0_addr;
   logic [7:0]           req0_wdata;

   logic                 req1_valid;
   logic                 req1_ready;
   logic                 req1_wr;
   logic [ADDR_SIZE-1:0] req1_addr;
   logic [7:0]           req1_wdata;

   logic                 resp0_valid;
   logic                 resp1_valid;
   logic [7:0]           resp_rdata;
   logic                 resp_err;

   logic [9:0]           ram_din;
   logic                 ram_rx_valid;
   logic [7:0]           ram_dout;
   logic                 ram_tx_valid;

   modport slave (
      input  req0_valid, req0_wr, req0_addr, req0_wdata,
      input  req1_valid, req1_wr, req1_addr, req1_wdata,
      output req0_ready, req1_ready,
      output resp0_valid, resp1_valid, resp_rdata, resp_err,
      output ram_din, ram_rx_valid,
      input  ram_dout, ram_tx_valid
   );

   modport master (
      output req0_valid, req0_wr, req0_addr, req0_wdata,
      output req1_valid, req1_wr, req1_addr, req1_wdata,
      input  req0_ready, req1_ready,
      input  resp0_valid, resp1_valid, resp_rdata, resp_err,
      input  ram_din, ram_rx_valid,
      output ram_dout, ram_tx_valid
   );
endinterface

// File: rtl/ram_cmd_arbiter.sv
// -----------------------------------------------------------------------------
// ram_cmd_arbiter
//
// Purpose : Shares the 10-bit command port of a single-port synchronous RAM
//           between two requesters with round-robin arbitration. A granted
//           transaction is expanded into the RAM's two-word command sequence
//           (address word, then data word or read-data request), read data is
//           awaited with a bounded timeout, and a single-cycle response is
//           returned to the requester that owned the transaction.
//
// Parameters
//   ADDR_SIZE  RAM address width (<= 8, zero-extended into the 8-bit payload)
//   TIMEOUT    RWAIT cycles tolerated without ram_tx_valid before aborting
//   TO_W       timeout counter width, 2**TO_W > TIMEOUT
//
// Ports
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   ram_cmd_arbiter_if.slave: requester channels, response bus, RAM side
//
// Command codes on ram_din[9:8]
//   00 write-address, 01 write-data, 10 read-address, 11 read-data request
// -----------------------------------------------------------------------------
module ram_cmd_arbiter #(
   parameter int ADDR_SIZE = 8,
   parameter int TIMEOUT   = 15,
   parameter int TO_W      = 4
) (
   input  logic                clk,
   input  logic                rst,
   ram_cmd_arbiter_if.slave    bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_WDATA,
      S_RCMD,
      S_RWAIT,
      S_RESP
   } state_t;

   localparam logic [1:0] OP_WADDR = 2'b00;
   localparam logic [1:0] OP_WDATA = 2'b01;
   localparam logic [1:0] OP_RADDR = 2'b10;
   localparam logic [1:0] OP_RDATA = 2'b11;

   state_t               r_state;
   state_t               w_state_nxt;

   // Latched transaction fields and arbitration history
   logic                 r_last_grant;
   logic                 r_port;
   logic                 r_wr;
   logic [ADDR_SIZE-1:0] r_addr;
   logic [7:0]           r_wdata;

   // Read timeout and response registers
   logic [TO_W-1:0]      r_to_cnt;
   logic [7:0]           r_resp_rdata;
   logic                 r_resp_err;

   logic                 w_grant0;
   logic                 w_grant1;
   logic                 w_timeout;
   logic [7:0]           w_addr_pay;
   logic [9:0]           w_ram_din;
   logic                 w_ram_rx_valid;

   assign w_addr_pay = 8'(r_addr);
   assign w_timeout  = (r_to_cnt == TO_W'(TIMEOUT));

   // Round-robin grant. Only meaningful in IDLE; a tie goes to the port that
   // did not win last time. Held low during reset so that every output reads
   // zero while rst is asserted.
   always_comb begin
      w_grant0 = 1'b0;
      w_grant1 = 1'b0;
      if ((r_state == S_IDLE) && !rst) begin
         w_grant0 = bus.req0_valid && (!bus.req1_valid ||  r_last_grant);
         w_grant1 = bus.req1_valid && (!bus.req0_valid || !r_last_grant);
      end
   end

   assign bus.req0_ready = w_grant0;
   assign bus.req1_ready = w_grant1;

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_grant0 || w_grant1) begin
               w_state_nxt = S_ADDR;
            end
         end
         S_ADDR: begin
            w_state_nxt = r_wr ? S_WDATA : S_RCMD;
         end
         S_WDATA: begin
            w_state_nxt = S_RESP;
         end
         S_RCMD: begin
            w_state_nxt = S_RWAIT;
         end
         S_RWAIT: begin
            if (bus.ram_tx_valid || w_timeout) begin
               w_state_nxt = S_RESP;
            end
         end
         S_RESP: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // RAM command decode: depends only on registered state and latched fields,
   // so nothing on the requester inputs can reach ram_din/ram_rx_valid.
   always_comb begin
      w_ram_din      = 10'h000;
      w_ram_rx_valid = 1'b0;
      case (r_state)
         S_ADDR: begin
            w_ram_rx_valid = 1'b1;
            w_ram_din      = {(r_wr ? OP_WADDR : OP_RADDR), w_addr_pay};
         end
         S_WDATA: begin
            w_ram_rx_valid = 1'b1;
            w_ram_din      = {OP_WDATA, r_wdata};
         end
         S_RCMD: begin
            w_ram_rx_valid = 1'b1;
            w_ram_din      = {OP_RDATA, 8'h00};
         end
         default: begin
            w_ram_rx_valid = 1'b0;
            w_ram_din      = 10'h000;
         end
      endcase
   end

   assign bus.ram_din      = w_ram_din;
   assign bus.ram_rx_valid = w_ram_rx_valid;

   // Response pulse is steered to the port captured at accept time.
   assign bus.resp0_valid = (r_state == S_RESP) && !r_port;
   assign bus.resp1_valid = (r_state == S_RESP) &&  r_port;
   assign bus.resp_rdata  = r_resp_rdata;
   assign bus.resp_err    = r_resp_err;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Transaction capture, timeout counter and response data
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_last_grant <= 1'b1;
         r_port       <= 1'b0;
         r_wr         <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= 8'h00;
         r_to_cnt     <= '0;
         r_resp_rdata <= 8'h00;
         r_resp_err   <= 1'b0;
      end else begin
         // Fields are frozen at accept; later input changes are ignored.
         if (w_grant0 || w_grant1) begin
            r_port       <= w_grant1;
            r_last_grant <= w_grant1;
            r_wr         <= w_grant1 ? bus.req1_wr    : bus.req0_wr;
            r_addr       <= w_grant1 ? bus.req1_addr  : bus.req0_addr;
            r_wdata      <= w_grant1 ? bus.req1_wdata : bus.req0_wdata;
         end
         case (r_state)
            S_WDATA: begin
               r_resp_rdata <= 8'h00;
               r_resp_err   <= 1'b0;
            end
            S_RCMD: begin
               r_to_cnt <= '0;
            end
            S_RWAIT: begin
               // Counter starts at 0 on the first RWAIT cycle, so the abort
               // lands TIMEOUT+1 cycles after RWAIT is entered.
               if (bus.ram_tx_valid) begin
                  r_resp_rdata <= bus.ram_dout;
                  r_resp_err   <= 1'b0;
               end else if (w_timeout) begin
                  r_resp_rdata <= 8'hFF;
                  r_resp_err   <= 1'b1;
               end else begin
                  r_to_cnt <= r_to_cnt + TO_W'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: doc/ram_cmd_arbiter.md
Name: ram_cmd_arbiter

Overview:
- Shares the 10-bit command interface of the single-port sync RAM between two requesters, port 0 and port 1, using round-robin arbitration.
- Each requester presents one complete transaction: op, address and write data.
- The block turns that transaction into the RAM's two-word command sequence, waits for read data and returns a one-cycle response.
- It sits between the SPI slave/host logic and the RAM instance.

Parameters:
- ADDR_SIZE, 8: RAM address width. The command word is always {op[1:0], payload[7:0]}, so ADDR_SIZE must be ≤ 8. The address is zero-extended into the payload.
- TIMEOUT, 15: RWAIT cycles allowed without ram_tx_valid before a read is aborted with an error.
- TO_W, 4: width of the timeout counter. TO_W must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0_valid / req1_valid  in  1  requester has a transaction pending.
- req0_ready / req1_ready  out  1  transaction accepted this cycle (transfer when valid & ready).
- req0_wr / req1_wr  in  1  1 = write, 0 = read.
- req0_addr / req1_addr  in  ADDR_SIZE  RAM address.
- req0_wdata / req1_wdata  in  8  write data (ignored for reads).
- resp0_valid / resp1_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  8  read data; shared by both ports, qualified by respN_valid.
- resp_err  out  1  timeout flag, qualified by respN_valid.
- ram_din  out  10  command word to the RAM.
- ram_rx_valid  out  1  command strobe to the RAM.
- ram_dout  in  8  RAM read data.
- ram_tx_valid  in  1  RAM read-data valid.

Behaviour:
- RAM command codes: 00 = write-address, 01 = write-data, 10 = read-address, 11 = read-data. The RAM registers dout and tx_valid one cycle after the 11 command.
- Reset: on assertion of rst, asynchronously go to IDLE. All outputs go to 0, last_grant = 1 (so port 0 wins the first tie), the timeout counter clears and latched request fields clear. Reset mid-transaction abandons the transaction with no response.
- FSM states: IDLE, ADDR, WDATA, RCMD, RWAIT, RESP.
- IDLE:
  - ram_rx_valid = 0.
  - reqN_ready is combinational from state, last_grant and reqN_valid. Only one ready may be high at a time, and ready is high only in IDLE.
  - Only one valid: grant it.
  - Both valid: grant the port not equal to last_grant.
  - On grant: latch wr, addr, wdata and port id; update last_grant; go to ADDR.
- ADDR (1 cycle): ram_rx_valid = 1, ram_din = {wr ? 2'b00 : 2'b10, addr}. Next state is WDATA for a write, RCMD for a read.
- WDATA (1 cycle): ram_rx_valid = 1, ram_din = {2'b01, wdata}. Next state RESP with resp_rdata = 0 and resp_err = 0.
- RCMD (1 cycle): ram_rx_valid = 1, ram_din = {2'b11, 8'h00}. Clear the timeout counter. Next state RWAIT.
- RWAIT:
  - ram_rx_valid = 0.
  - If ram_tx_valid = 1: capture ram_dout into resp_rdata, set resp_err = 0, go to RESP.
  - Else increment the counter. When the counter reaches TIMEOUT: resp_rdata = 8'hFF, resp_err = 1, go to RESP.
- RESP (1 cycle): assert resp_valid for the latched port only, then go to IDLE. There is no response backpressure.
- Outside ADDR/WDATA/RCMD: ram_rx_valid = 0 and ram_din = 0.
- ram_din and ram_rx_valid are decoded from registered state and latched fields. There is no combinational path from req* inputs to ram_*.
- Latency from the accept cycle (cycle 0):
  - Write: ADDR at c1, WDATA at c2, resp_valid at c3.
  - Read against a compliant RAM: ADDR c1, RCMD c2, RWAIT c3 (tx_valid seen), resp_valid c4.
- Back-to-back: a new grant is possible in the cycle after RESP (IDLE). Minimum period is 4 cycles per write and 5 per read.
- Input changes after acceptance: req fields are latched at accept, so later changes have no effect.
- ram_tx_valid outside RWAIT: ignored.
- resp_rdata and resp_err hold their last values between responses.

Test Plan:
- Write: req0 write addr 8'h3C, data 8'hA5 → req0_ready at c0; ram_din = 10'h03C at c1 and 10'h1A5 at c2, each with rx_valid; resp0_valid at c3 with err 0.
- Read-back: after the write above, req1 read addr 8'h3C → ram_din = 10'h23C at c1 and 10'h300 at c2; resp1_valid at c4 with resp_rdata = 8'hA5.
- Contention: req0 and req1 held valid continuously (writes to 8'h01 and 8'h02) → grants alternate 0, 1, 0, 1 starting with 0; no cycle has both readys high; 4 completions in 16 cycles.
- Timeout: read with the RAM model's tx_valid forced to 0 → resp_valid exactly TIMEOUT+1 cycles after entering RWAIT, with resp_rdata = 8'hFF and resp_err = 1; the next request is then serviced normally.
- Reset mid-op: assert rst during WDATA → ram_rx_valid, all readys and all resps drop immediately (asynchronously); no resp pulse; after release, req1 and req0 both valid → port 0 granted first.
- Request-data stability: change req0_addr and req0_wdata in the cycle after accept → ram_din still carries the values latched at accept.
